dcache_responder: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache that serves the core's MEM-stage load/store traffic.
- Replaces the tied-off DCacheMiss path: its `miss` output feeds the hazard unit's DCacheMiss input and stalls the pipeline.
- Backing store is reached over a single-word req/ack bus.
- Sits between the MEM/WB segment and main memory.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_data_ram.sv | 33 +++
 rtl/dcache_responder.sv | 208 ++++++++++++++++++++
 tb/tb_dcache_responder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared geometry, FSM states and line metadata for the direct-mapped data cache.
package dcache_pkg;

  localparam int DEF_SETS       = 64;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_ADDR_WIDTH = 32;

  localparam int OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int TAG_W = DEF_ADDR_WIDTH - IDX_W - OFF_W - 2;

  // Tags are kept zero-extended so other SETS/LINE_WORDS choices still fit.
  localparam int META_TAG_W = DEF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WBACK,
    FILL
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [META_TAG_W-1:0] tag;
  } lineMeta_t;

endpackage

// File: rtl/dcache_data_ram.sv
// Cache data store: one port, byte write enables, registered read (1 cycle).
// Read register only updates on read accesses, so it holds between loads.
module dcache_data_ram
  import dcache_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [3:0]                          we,
  input  logic [$clog2(SETS*LINE_WORDS)-1:0]  addr,
  input  logic [31:0]                         wdata,
  output logic [31:0]                         rdata
);

  logic [31:0] mem [SETS*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (en && we == 4'b0) rdata <= mem[addr];
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate D-cache; DCACHE_STATS_EN adds hit/miss counters.
// Load data one cycle after a hit; miss stalls the core while the line is written back and refilled.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [3:0]            wr_be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  miss,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int SH = OW + IW + 2;

  state_t                state, stateNext;
  lineMeta_t             meta [SETS];
  logic [ADDR_WIDTH-1:0] reqAddr;
  logic [OW-1:0]         beat, beatNext, off;
  logic [IW-1:0]         idx, reqIdx;
  logic [META_TAG_W-1:0] tagIn, reqTag;
  logic                  store, active, hit, victimDirty, lastBeat;

  logic                  ramEn;
  logic [3:0]            ramWe;
  logic [IW+OW-1:0]      ramAddr;
  logic [31:0]           ramWdata, ramQ;

  assign store       = |wr_be;
  assign active      = rd_req | store;
  assign idx         = addr[OW+2 +: IW];
  assign off         = addr[2 +: OW];
  assign tagIn       = META_TAG_W'(addr >> SH);
  assign reqIdx      = reqAddr[OW+2 +: IW];
  assign reqTag      = META_TAG_W'(reqAddr >> SH);
  assign hit         = meta[idx].valid && (meta[idx].tag == tagIn);
  assign victimDirty = meta[idx].valid && meta[idx].dirty;
  assign lastBeat    = &beat;
  assign beatNext    = beat + 1'b1;

  function automatic logic [ADDR_WIDTH-1:0] beatAddr(input logic [META_TAG_W-1:0] t,
                                                     input logic [IW-1:0] i,
                                                     input logic [OW-1:0] k);
    return (ADDR_WIDTH'(t) << SH) | ADDR_WIDTH'({i, k, 2'b00});
  endfunction

  always_comb begin
    stateNext = state;
    miss      = 1'b0;
    ramEn     = 1'b0;
    ramWe     = 4'b0;
    ramAddr   = {idx, off};
    ramWdata  = wr_data;
    case (state)
      IDLE: begin
        if (active) begin
          if (hit) begin
            ramEn = 1'b1;
            ramWe = wr_be;
          end else begin
            miss = 1'b1;
            if (victimDirty) begin
              // Prefetch victim word 0 so it is on mem_wdata with the first write beat.
              stateNext = WBACK;
              ramEn     = 1'b1;
              ramAddr   = {idx, {OW{1'b0}}};
            end else begin
              stateNext = FILL;
            end
          end
        end
      end
      WBACK: begin
        miss = 1'b1;
        if (mem_ack) begin
          if (lastBeat) begin
            stateNext = FILL;
          end else begin
            ramEn   = 1'b1;
            ramAddr = {reqIdx, beatNext};
          end
        end
      end
      FILL: begin
        miss = 1'b1;
        if (mem_ack) begin
          ramEn    = 1'b1;
          ramWe    = 4'hF;
          ramAddr  = {reqIdx, beat};
          ramWdata = mem_rdata;
          if (lastBeat) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      for (int s = 0; s < SETS; s++) meta[s] <= '0;
      reqAddr  <= '0;
      beat     <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (active) begin
            if (hit) begin
              if (store) meta[idx].dirty <= 1'b1;
            end else begin
              reqAddr  <= addr;
              beat     <= '0;
              mem_req  <= 1'b1;
              mem_we   <= victimDirty;
              mem_addr <= victimDirty ? beatAddr(meta[idx].tag, idx, '0) : beatAddr(tagIn, idx, '0);
            end
          end
        end
        WBACK: begin
          if (mem_ack) begin
            beat <= beatNext;
            if (lastBeat) begin
              mem_we   <= 1'b0;
              mem_addr <= beatAddr(reqTag, reqIdx, '0);
            end else begin
              mem_addr <= beatAddr(meta[reqIdx].tag, reqIdx, beatNext);
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            beat <= beatNext;
            if (lastBeat) begin
              mem_req      <= 1'b0;
              meta[reqIdx] <= '{valid: 1'b1, dirty: 1'b0, tag: reqTag};
            end else begin
              mem_addr <= beatAddr(reqTag, reqIdx, beatNext);
            end
          end
        end
        default: ;
      endcase
    end
  end

  dcache_data_ram #(
    .SETS      (SETS),
    .LINE_WORDS(LINE_WORDS)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .en   (ramEn),
    .we   (ramWe),
    .addr (ramAddr),
    .wdata(ramWdata),
    .rdata(ramQ)
  );

  // The RAM read register doubles as load result and write-back beat data.
  assign rd_data   = ramQ;
  assign mem_wdata = ramQ;

`ifdef DCACHE_STATS_EN
  logic        replay;
  logic [31:0] hitCnt, missCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay  <= 1'b0;
      hitCnt  <= '0;
      missCnt <= '0;
    end else begin
      replay <= (state == FILL) && mem_ack && lastBeat;
      if (state == IDLE && active) begin
        if (hit && !replay) hitCnt <= hitCnt + 32'd1;
        if (!hit) missCnt <= missCnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = hitCnt;
  assign miss_cnt = missCnt;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed table, corner sequences, randomized traffic vs. reference model.
module tb_dcache_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [3:0]  wr_be;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always #5 clk = ~clk;

  dcache_responder dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .wr_be    (wr_be),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .miss     (miss),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  int nTests = 0;
  int nFail  = 0;
  int ackDelay = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic        rd;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] wd;
    int          expMiss;
    logic        chkRd;
    logic [31:0] expRd;
  } vec_t;

  logic [31:0] memArr [int unsigned];
  logic [31:0] gold   [int unsigned];
  beat_t       beats  [$];
  bit          mValid [64];
  bit          mDirty [64];
  int unsigned mTag   [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memArr.exists(a)) return memArr[a];
    return a ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [31:0] arch(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return memRead(a);
  endfunction

  // Backing memory: acks each beat after ackDelay idle cycles, checks request stability.
  initial begin : responder
    int          waitCnt;
    logic [31:0] holdAddr, holdWdata;
    logic        holdWe;
    waitCnt   = 0;
    holdAddr  = '0;
    holdWdata = '0;
    holdWe    = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) begin
        mem_ack = 1'b0;
        waitCnt = 0;
      end else begin
        if (waitCnt == 0) begin
          holdAddr  = mem_addr;
          holdWe    = mem_we;
          holdWdata = mem_wdata;
        end else begin
          check("beatAddrHeld", mem_addr, holdAddr);
          check("beatWeHeld", 32'(mem_we), 32'(holdWe));
          if (holdWe) check("beatWdataHeld", mem_wdata, holdWdata);
        end
        if (waitCnt >= ackDelay) begin
          mem_ack = 1'b1;
          waitCnt = 0;
          beats.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
          if (mem_we) memArr[mem_addr] = mem_wdata;
          mem_rdata = mem_we ? $urandom : memRead(mem_addr);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          waitCnt++;
        end
      end
    end
  end

  task automatic doAccess(input logic rd, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd, output int nMiss, output logic [31:0] rdv);
    @(negedge clk);
    rd_req  = rd;
    wr_be   = be;
    addr    = a;
    wr_data = wd;
    nMiss   = 0;
    #1;
    while (miss === 1'b1 && nMiss < 500) begin
      nMiss++;
      @(negedge clk);
      #1;
    end
    if (nMiss >= 500) check("accessTimeout", 32'(miss), 32'd0);
    @(posedge clk);
    #1;
    rdv    = rd_data;
    rd_req = 1'b0;
    wr_be  = 4'b0;
  endtask

  task automatic resetDut();
    rst     = 1'b1;
    rd_req  = 1'b0;
    wr_be   = 4'b0;
    addr    = '0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 64; s++) begin
      mValid[s] = 1'b0;
      mDirty[s] = 1'b0;
    end
    gold.delete();
  endtask

  task automatic modelAccess(input logic rd, input logic [3:0] be, input logic [31:0] a,
                             input logic [31:0] wd, input int d);
    int unsigned i, t;
    bit          hitM;
    int          expMiss, nMiss;
    logic [31:0] rdv, cur;
    i       = (a >> 4) & 32'd63;
    t       = a >> 10;
    hitM    = mValid[i] && (mTag[i] == t);
    expMiss = hitM ? 0 : (((mValid[i] && mDirty[i]) ? 8 : 4) * (d + 1) + 1);
    ackDelay = d;
    doAccess(rd, be, a, wd, nMiss, rdv);
    check("rndMissCycles", 32'(nMiss), 32'(expMiss));
    if (be == 4'b0) begin
      check("rndLoad", rdv, arch(a));
    end else begin
      cur = arch(a);
      for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
      gold[a] = cur;
    end
    if (!hitM) mDirty[i] = 1'b0;
    if (be != 4'b0) mDirty[i] = 1'b1;
    mValid[i] = 1'b1;
    mTag[i]   = t;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t        vecs [4];
    int          nMiss, g;
    logic [31:0] rdv;

    rst     = 1'b1;
    rd_req  = 1'b0;
    wr_be   = 4'b0;
    addr    = '0;
    wr_data = '0;
    memArr[32'h100]  = 32'hDEADBEEF;
    memArr[32'h1100] = 32'hCAFE1100;

    vecs[0] = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         5, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 4'h3, 32'h0000_0100, 32'h0000_1234, 0, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         0, 1'b1, 32'hDEAD1234};
    vecs[3] = '{1'b1, 4'h0, 32'h0000_1100, 32'h0,         9, 1'b1, 32'hCAFE1100};

    repeat (2) @(negedge clk);
    #1;
    check("rstRdData", rd_data, 32'h0);
    check("rstMiss", 32'(miss), 32'd0);
    check("rstMemReq", 32'(mem_req), 32'd0);
    check("rstMemWe", 32'(mem_we), 32'd0);
    check("rstMemAddr", mem_addr, 32'h0);
    check("rstMemWdata", mem_wdata, 32'h0);
    check("rstHitCnt", hit_cnt, 32'h0);
    check("rstMissCnt", miss_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      beats.delete();
      ackDelay = 0;
      doAccess(vecs[v].rd, vecs[v].be, vecs[v].a, vecs[v].wd, nMiss, rdv);
      check($sformatf("vec%0d_missCycles", v), 32'(nMiss), 32'(vecs[v].expMiss));
      if (vecs[v].chkRd) check($sformatf("vec%0d_rdData", v), rdv, vecs[v].expRd);
    end

    // Dirty eviction of 0x100 line by 0x1100: four writes then four reads.
    check("evictBeatCount", 32'(beats.size()), 32'd8);
    for (int k = 0; k < 8 && k < beats.size(); k++) begin
      check($sformatf("evictWe%0d", k), 32'(beats[k].we), (k < 4) ? 32'd1 : 32'd0);
      check($sformatf("evictAddr%0d", k), beats[k].addr,
            ((k < 4) ? 32'h100 : 32'h1100) + 32'(4 * (k % 4)));
    end
    if (beats.size() > 0) check("evictWdata0", beats[0].wdata, 32'hDEAD1234);

    ackDelay = 3;
    doAccess(1'b1, 4'h0, 32'h0000_2100, 32'h0, nMiss, rdv);
    check("slowAckMissCycles", 32'(nMiss), 32'd17);
    check("slowAckRdData", rdv, memRead(32'h2100));

    // Reset while the second fill beat is outstanding.
    ackDelay = 2;
    beats.delete();
    @(negedge clk);
    rd_req = 1'b1;
    addr   = 32'h0000_3100;
    g = 0;
    while (beats.size() == 0 && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("midFillFirstAck", 32'(beats.size()), 32'd1);
    @(posedge clk);
    #1;
    check("midFillBeat1Addr", mem_addr, 32'h3104);
    check("midFillReqHigh", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("midRstMemReq", 32'(mem_req), 32'd0);
    check("midRstMemAddr", mem_addr, 32'h0);
    check("midRstRdData", rd_data, 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    rd_req = 1'b0;
    addr   = '0;
    ackDelay = 0;
    doAccess(1'b1, 4'h0, 32'h0000_3100, 32'h0, nMiss, rdv);
    check("postRstMissCycles", 32'(nMiss), 32'd5);
    check("postRstRdData", rdv, memRead(32'h3100));
    doAccess(1'b1, 4'h0, 32'h0000_0100, 32'h0, nMiss, rdv);
    check("writtenBackMissCycles", 32'(nMiss), 32'd5);
    check("writtenBackRdData", rdv, 32'hDEAD1234);

    // Counters: one miss then three hits.
    resetDut();
    check("statsRstHit", hit_cnt, 32'h0);
    check("statsRstMiss", miss_cnt, 32'h0);
    doAccess(1'b1, 4'h0, 32'h0000_5000, 32'h0, nMiss, rdv);
    check("statsMissCycles", 32'(nMiss), 32'd5);
    doAccess(1'b1, 4'h0, 32'h0000_5000, 32'h0, nMiss, rdv);
    doAccess(1'b1, 4'h0, 32'h0000_5004, 32'h0, nMiss, rdv);
    doAccess(1'b0, 4'hF, 32'h0000_5008, 32'h1234_5678, nMiss, rdv);
    check("statsHitMissCycles", 32'(nMiss), 32'd0);
`ifdef DCACHE_STATS_EN
    check("statsMissCnt", miss_cnt, 32'd1);
    check("statsHitCnt", hit_cnt, 32'd3);
`else
    check("statsMissCnt", miss_cnt, 32'd0);
    check("statsHitCnt", hit_cnt, 32'd0);
`endif

    resetDut();
    for (int n = 0; n < 250; n++) begin
      int unsigned t, i, o;
      logic [31:0] a, wd;
      logic [3:0]  be;
      logic        rd;
      t  = $urandom_range(0, 3);
      i  = $urandom_range(0, 3);
      o  = $urandom_range(0, 3);
      a  = (t << 10) | (i << 4) | (o << 2);
      be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rd = (be == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1));
      wd = $urandom;
      modelAccess(rd, be, a, wd, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
